// File: rtl/redmule_tile_fixture_pkg.sv
// Shared types and constants for the RedMulE tile fixture controller.
package redmule_tile_fixture_pkg;

  // Controller state; the encoding is visible to the host through STATUS.
  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_IDLE       = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  // Register offsets inside the 4 KiB control window
  localparam logic [11:0] OFF_BOOT_ADDR = 12'h000;
  localparam logic [11:0] OFF_CTRL      = 12'h004;
  localparam logic [11:0] OFF_STATUS    = 12'h008;
  localparam logic [11:0] OFF_EXIT_CODE = 12'h00C;

  // STATUS layout: {29'b0, state[1:0], eoc}
  localparam int unsigned STATUS_EOC_BIT   = 0;
  localparam int unsigned STATUS_STATE_LSB = 1;

  // CTRL bit that requests a core start
  localparam int unsigned CTRL_START_BIT = 0;

endpackage

// File: rtl/redmule_tile_fixture_regs.sv
// Register file of the fixture controller: boot address, EOC mailbox and
// the host read mux for the control window.
module redmule_tile_fixture_regs
  import redmule_tile_fixture_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] BOOT_RST = 32'h0000_0080
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  state_e            state,
  input  logic              wr_en,
  input  logic [11:0]       offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              eoc_take,
  input  logic [DATA_W-1:0] eoc_data,
  output logic [ADDR_W-1:0] boot_addr,
  output logic              eoc,
  output logic [DATA_W-1:0] exit_code,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] boot_addr_r;
  logic              eoc_r;
  logic [DATA_W-1:0] exit_code_r;
  logic [DATA_W-1:0] rdata_s;

  // Boot address is host-writable; wr_en is only raised while the core is idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_r <= BOOT_RST;
    end else if (wr_en && (offset == OFF_BOOT_ADDR)) begin
      boot_addr_r <= wdata[ADDR_W-1:0];
    end else begin
      boot_addr_r <= boot_addr_r;
    end
  end

  // EOC mailbox: the top only raises eoc_take once, so the first exit code sticks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eoc_r       <= 1'b0;
      exit_code_r <= '0;
    end else if (eoc_take) begin
      eoc_r       <= 1'b1;
      exit_code_r <= eoc_data;
    end else begin
      eoc_r       <= eoc_r;
      exit_code_r <= exit_code_r;
    end
  end

  // Host read mux; CTRL and unmapped offsets read as zero
  always_comb begin
    rdata_s = '0;
    case (offset)
      OFF_BOOT_ADDR: rdata_s[ADDR_W-1:0] = boot_addr_r;
      OFF_STATUS: begin
        rdata_s[STATUS_EOC_BIT]        = eoc_r;
        rdata_s[STATUS_STATE_LSB +: 2] = state;
      end
      OFF_EXIT_CODE: rdata_s = exit_code_r;
      default:       rdata_s = '0;
    endcase
  end

  assign boot_addr = boot_addr_r;
  assign eoc       = eoc_r;
  assign exit_code = exit_code_r;
  assign rdata     = rdata_s;

endmodule

// File: rtl/redmule_tile_fixture_ctrl.sv
// Boot / end-of-computation controller for the RedMulE tile fixture.
// Host accesses inside the control window hit local registers; all other
// accesses are forwarded to the memory port for preloading.
module redmule_tile_fixture_ctrl
  import redmule_tile_fixture_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] CTRL_BASE  = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] BOOT_RST   = 32'h0000_0080,
  parameter int unsigned       RST_SETTLE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              core_eoc_req_i,
  input  logic [DATA_W-1:0] core_eoc_data_i,
  output logic              fetch_en_o,
  output logic [ADDR_W-1:0] boot_addr_o,
  output logic              eoc_o,
  output logic [DATA_W-1:0] exit_code_o
);

  localparam int unsigned CNT_W = $clog2(RST_SETTLE + 1);

  state_e            state_r;
  logic [CNT_W-1:0]  settle_cnt_r;
  logic              fetch_en_r;
  logic              win_rvalid_r;
  logic [DATA_W-1:0] win_rdata_r;

  logic              win_hit_s;
  logic [11:0]       offset_s;
  logic              host_open_s;
  logic              win_gnt_s;
  logic              pt_sel_s;
  logic              start_s;
  logic              eoc_take_s;
  logic              reg_wr_s;
  logic [DATA_W-1:0] reg_rdata_s;

  // Address decode and the qualified events that drive the FSM and registers
  always_comb begin
    win_hit_s   = (host_addr_i[ADDR_W-1:12] == CTRL_BASE[ADDR_W-1:12]);
    offset_s    = host_addr_i[11:0];
    host_open_s = (state_r != ST_RESET_WAIT);
    win_gnt_s   = host_req_i & win_hit_s & host_open_s;
    pt_sel_s    = host_req_i & ~win_hit_s & host_open_s;
    start_s     = win_gnt_s & host_we_i & (offset_s == OFF_CTRL)
                  & host_wdata_i[CTRL_START_BIT] & (state_r == ST_IDLE);
    eoc_take_s  = core_eoc_req_i & (state_r == ST_RUN);
    reg_wr_s    = win_gnt_s & host_we_i & (state_r == ST_IDLE);
  end

  // Control FSM: settle after reset, wait for START, run until the core reports EOC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_RESET_WAIT;
      settle_cnt_r <= '0;
      fetch_en_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET_WAIT: begin
          if (settle_cnt_r == CNT_W'(RST_SETTLE - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_RUN;
            fetch_en_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (eoc_take_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: state_r <= ST_DONE;
        default: begin
          state_r    <= ST_RESET_WAIT;
          fetch_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Window response: one cycle after grant; writes answer with zero data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_rvalid_r <= 1'b0;
      win_rdata_r  <= '0;
    end else begin
      win_rvalid_r <= win_gnt_s;
      win_rdata_r  <= (win_gnt_s && !host_we_i) ? reg_rdata_s : '0;
    end
  end

  redmule_tile_fixture_regs #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BOOT_RST (BOOT_RST)
  ) u_regs (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .state     (state_r),
    .wr_en     (reg_wr_s),
    .offset    (offset_s),
    .wdata     (host_wdata_i),
    .eoc_take  (eoc_take_s),
    .eoc_data  (core_eoc_data_i),
    .boot_addr (boot_addr_o),
    .eoc       (eoc_o),
    .exit_code (exit_code_o),
    .rdata     (reg_rdata_s)
  );

  // Pass-through forwarding and host response steering; window response wins
  always_comb begin
    mem_req_o  = pt_sel_s;
    mem_we_o   = pt_sel_s & host_we_i;
    host_gnt_o = win_gnt_s | (pt_sel_s & mem_gnt_i);
    if (pt_sel_s) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
    end else begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
    if (win_rvalid_r) begin
      host_rvalid_o = 1'b1;
      host_rdata_o  = win_rdata_r;
    end else if (host_open_s) begin
      host_rvalid_o = mem_rvalid_i;
      host_rdata_o  = mem_rdata_i;
    end else begin
      host_rvalid_o = 1'b0;
      host_rdata_o  = '0;
    end
  end

  assign fetch_en_o = fetch_en_r;

endmodule

// File: tb/tb_redmule_tile_fixture_ctrl.sv
// Directed self-checking bench for redmule_tile_fixture_ctrl.
module tb_redmule_tile_fixture_ctrl;

  localparam logic [31:0] WIN       = 32'hFFFF_0000;
  localparam logic [31:0] A_BOOT    = WIN + 32'h0000_0000;
  localparam logic [31:0] A_CTRL    = WIN + 32'h0000_0004;
  localparam logic [31:0] A_STATUS  = WIN + 32'h0000_0008;
  localparam logic [31:0] A_EXIT    = WIN + 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        eoc_req = 1'b0;
  logic [31:0] eoc_data = '0;
  logic        fetch_en;
  logic [31:0] boot_addr;
  logic        eoc;
  logic [31:0] exit_code;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic [31:0] mem_arr [0:15];

  redmule_tile_fixture_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .host_req_i      (host_req),
    .host_we_i       (host_we),
    .host_addr_i     (host_addr),
    .host_wdata_i    (host_wdata),
    .host_gnt_o      (host_gnt),
    .host_rvalid_o   (host_rvalid),
    .host_rdata_o    (host_rdata),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .core_eoc_req_i  (eoc_req),
    .core_eoc_data_i (eoc_data),
    .fetch_en_o      (fetch_en),
    .boot_addr_o     (boot_addr),
    .eoc_o           (eoc),
    .exit_code_o     (exit_code)
  );

  always #5 clk = ~clk;

  // Simple memory responder: always grants, answers one cycle later
  assign mem_gnt = mem_req;
  always @(posedge clk) begin
    mem_rvalid <= mem_req;
    if (mem_req && mem_we) begin
      mem_arr[mem_addr[5:2]] <= mem_wdata;
      mem_rdata <= '0;
    end else if (mem_req) begin
      mem_rdata <= mem_arr[mem_addr[5:2]];
    end else begin
      mem_rdata <= '0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One host transaction with bounded waits for grant and response
  task automatic host_xfer(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    #1;
    n = 0;
    while (!host_gnt && n < 16) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq({tag, "_gnt"}, {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    n = 0;
    while (!host_rvalid && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    rdata = host_rdata;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
    check_eq("rst_boot_addr", boot_addr, 32'h0000_0080);
    check_eq("rst_eoc", {31'd0, eoc}, 32'd0);
    check_eq("rst_exit_code", exit_code, 32'd0);
    check_eq("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);

    // Release reset and hold a STATUS read request through RESET_WAIT
    rst_n = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = A_STATUS;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("rstwait_gnt_%0d", i), {31'd0, host_gnt}, 32'd0);
      @(posedge clk); #1;
    end
    #1 check_eq("idle_gnt", {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0; host_addr = '0;
    check_eq("idle_rvalid", {31'd0, host_rvalid}, 32'd1);
    check_eq("idle_status", host_rdata, 32'h0000_0002);
    @(posedge clk); #1;
    check_eq("rvalid_one_cycle", {31'd0, host_rvalid}, 32'd0);

    // Preload through the pass-through port
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0000_1000; host_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("pt_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("pt_mem_we", {31'd0, mem_we}, 32'd1);
    check_eq("pt_mem_addr", mem_addr, 32'h0000_1000);
    check_eq("pt_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("pt_gnt", {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    check_eq("pt_wr_rvalid", {31'd0, host_rvalid}, 32'd1);
    host_xfer("pt_rd", 1'b0, 32'h0000_1000, 32'd0, rd);
    check_eq("pt_rd_data", rd, 32'hDEAD_BEEF);

    // Boot sequence
    host_xfer("wr_boot", 1'b1, A_BOOT, 32'h0000_2000, rd);
    check_eq("wr_boot_rdata", rd, 32'd0);
    check_eq("boot_addr_o", boot_addr, 32'h0000_2000);
    check_eq("pre_start_fetch", {31'd0, fetch_en}, 32'd0);
    host_xfer("start", 1'b1, A_CTRL, 32'd1, rd);
    check_eq("start_fetch_en", {31'd0, fetch_en}, 32'd1);
    host_xfer("rd_status_run", 1'b0, A_STATUS, 32'd0, rd);
    check_eq("status_run", rd, 32'h0000_0004);
    host_xfer("wr_boot_run", 1'b1, A_BOOT, 32'h0000_3000, rd);
    host_xfer("rd_boot_run", 1'b0, A_BOOT, 32'd0, rd);
    check_eq("boot_locked_rd", rd, 32'h0000_2000);
    check_eq("boot_locked_o", boot_addr, 32'h0000_2000);
    host_xfer("rd_ctrl", 1'b0, A_CTRL, 32'd0, rd);
    check_eq("ctrl_reads_zero", rd, 32'd0);

    // EOC with exit code 0, then a second strobe that must be ignored
    @(posedge clk); #1;
    eoc_req = 1'b1; eoc_data = 32'd0;
    @(posedge clk); #1;
    eoc_req = 1'b0;
    check_eq("eoc_set", {31'd0, eoc}, 32'd1);
    check_eq("eoc_exit_o", exit_code, 32'd0);
    host_xfer("rd_exit", 1'b0, A_EXIT, 32'd0, rd);
    check_eq("exit_code_rd", rd, 32'd0);
    host_xfer("rd_status_done", 1'b0, A_STATUS, 32'd0, rd);
    check_eq("status_done", rd, 32'h0000_0007);
    @(posedge clk); #1;
    eoc_req = 1'b1; eoc_data = 32'd5;
    @(posedge clk); #1;
    eoc_req = 1'b0; eoc_data = '0;
    check_eq("second_eoc_exit_o", exit_code, 32'd0);
    host_xfer("rd_exit2", 1'b0, A_EXIT, 32'd0, rd);
    check_eq("second_eoc_exit_rd", rd, 32'd0);
    check_eq("done_fetch_en", {31'd0, fetch_en}, 32'd1);

    // EOC before START is ignored; START and EOC together take START
    do_reset();
    eoc_req = 1'b1; eoc_data = 32'd9;
    @(posedge clk); #1;
    eoc_req = 1'b0; eoc_data = '0;
    check_eq("idle_eoc_ignored", {31'd0, eoc}, 32'd0);
    check_eq("idle_eoc_exit", exit_code, 32'd0);
    host_xfer("rd_status_idle2", 1'b0, A_STATUS, 32'd0, rd);
    check_eq("status_idle2", rd, 32'h0000_0002);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = A_CTRL; host_wdata = 32'd1;
    eoc_req = 1'b1; eoc_data = 32'h0000_0011;
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eoc_req = 1'b0; eoc_data = '0;
    check_eq("both_rvalid", {31'd0, host_rvalid}, 32'd1);
    check_eq("both_eoc", {31'd0, eoc}, 32'd0);
    check_eq("both_fetch_en", {31'd0, fetch_en}, 32'd1);
    host_xfer("rd_status_both", 1'b0, A_STATUS, 32'd0, rd);
    check_eq("status_both", rd, 32'h0000_0004);
    @(posedge clk); #1;
    eoc_req = 1'b1; eoc_data = 32'h0000_002A;
    @(posedge clk); #1;
    eoc_req = 1'b0; eoc_data = '0;
    check_eq("eoc2_set", {31'd0, eoc}, 32'd1);
    check_eq("eoc2_exit_o", exit_code, 32'h0000_002A);

    // Asynchronous reset while RUN with a window response pending
    do_reset();
    host_xfer("wr_boot3", 1'b1, A_BOOT, 32'h0000_4000, rd);
    host_xfer("start3", 1'b1, A_CTRL, 32'd1, rd);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = A_STATUS;
    @(posedge clk); #1;
    host_req = 1'b0; host_addr = '0;
    check_eq("pend_rvalid", {31'd0, host_rvalid}, 32'd1);
    check_eq("pend_fetch_en", {31'd0, fetch_en}, 32'd1);
    check_eq("pend_boot", boot_addr, 32'h0000_4000);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("arst_fetch_en", {31'd0, fetch_en}, 32'd0);
    check_eq("arst_boot", boot_addr, 32'h0000_0080);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
